// File: rtl/multi_operand_adder_pipe.sv
// Pipelined binary adder tree over NOPS unsigned operands with optional frame accumulation.
// Latency LOG2N+1 cycles; a held output (out_valid & ~out_ready) freezes every stage and deasserts in_ready.
module multi_operand_adder_pipe #(
  parameter int NOPS     = 8,
  parameter int W        = 7,
  parameter int ACC_BITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NOPS*W-1:0]                    in_data,
  input  logic                                 acc_mode,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W+$clog2(NOPS)+ACC_BITS-1:0]   out_sum,
  output logic                                 out_ovf
);

  localparam int LOG2N = $clog2(NOPS);
  localparam int OUTW  = W + LOG2N + ACC_BITS;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Level k holds NOPS>>k exact partial sums of W+k bits, plus the beat's side-band bits.
  for (genvar k = 1; k <= LOG2N; k++) begin : g_lvl
    localparam int NS = NOPS >> k;
    localparam int PW = W + k;

    logic [PW-2:0] a [2*NS];
    logic          src_vld;
    logic          src_mode;
    logic          src_last;

    logic [PW-1:0] sum [NS];
    logic          vld;
    logic          mode;
    logic          last;

    if (k == 1) begin : g_src
      for (genvar j = 0; j < 2*NS; j++) begin : g_op
        assign a[j] = in_data[j*W +: W];
      end
      assign src_vld  = in_valid;
      assign src_mode = acc_mode;
      assign src_last = in_last;
    end else begin : g_src
      for (genvar j = 0; j < 2*NS; j++) begin : g_op
        assign a[j] = g_lvl[k-1].sum[j];
      end
      assign src_vld  = g_lvl[k-1].vld;
      assign src_mode = g_lvl[k-1].mode;
      assign src_last = g_lvl[k-1].last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld  <= 1'b0;
        mode <= 1'b0;
        last <= 1'b0;
        for (int j = 0; j < NS; j++) sum[j] <= '0;
      end else if (!stall) begin
        vld  <= src_vld;
        mode <= src_mode;
        last <= src_last;
        for (int j = 0; j < NS; j++) sum[j] <= PW'(a[2*j]) + PW'(a[2*j+1]);
      end
    end
  end

  logic [OUTW-1:0] tree_sum;
  logic            top_vld;
  logic            top_mode;
  logic            top_last;
  logic [OUTW-1:0] acc;
  logic            ovf;
  logic [OUTW:0]   acc_sum;

  assign tree_sum = OUTW'(g_lvl[LOG2N].sum[0]);
  assign top_vld  = g_lvl[LOG2N].vld;
  assign top_mode = g_lvl[LOG2N].mode;
  assign top_last = g_lvl[LOG2N].last;
  assign acc_sum  = {1'b0, acc} + {1'b0, tree_sum};

  // Per-beat results and frame ends both publish and restart the accumulator from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      if (top_vld && (!top_mode || top_last)) begin
        out_valid <= 1'b1;
        out_sum   <= top_mode ? acc_sum[OUTW-1:0] : tree_sum;
        out_ovf   <= top_mode & (ovf | acc_sum[OUTW]);
        acc       <= '0;
        ovf       <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (top_vld) begin
          acc <= acc_sum[OUTW-1:0];
          ovf <= ovf | acc_sum[OUTW];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench for multi_operand_adder_pipe at default parameters (NOPS=8, W=7, ACC_BITS=4).
module tb_multi_operand_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_data;
  logic        acc_mode;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_sum;
  logic        out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  multi_operand_adder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .acc_mode  (acc_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [55:0] data;
    logic        mode;
    logic        last;
    logic [13:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  logic [55:0] bq_dat [$];
  logic        bq_mode[$];
  logic        bq_last[$];
  int          res_sum[$];
  int          res_ovf[$];
  int          res_cyc[$];

  function automatic logic [55:0] pk(input logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input logic [55:0] d, input logic m, input logic l);
    bq_dat.push_back(d);
    bq_mode.push_back(m);
    bq_last.push_back(l);
  endtask

  task automatic sample(input int cyc);
    if (out_valid && out_ready) begin
      res_sum.push_back(int'(out_sum));
      res_ovf.push_back(int'(out_ovf));
      res_cyc.push_back(cyc);
    end
  endtask

  // Streams queued beats back-to-back with out_ready=1; cycle 1 is the edge that accepts the first beat.
  task automatic run_stream(input int tail);
    int cyc;
    cyc = 0;
    res_sum.delete();
    res_ovf.delete();
    res_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < bq_dat.size(); i++) begin
      in_valid = 1'b1;
      in_data  = bq_dat[i];
      acc_mode = bq_mode[i];
      in_last  = bq_last[i];
      tick();
      cyc++;
      sample(cyc);
    end
    in_valid = 1'b0;
    acc_mode = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < tail; i++) begin
      tick();
      cyc++;
      sample(cyc);
    end
    bq_dat.delete();
    bq_mode.delete();
    bq_last.delete();
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [55:0] v_ramp, v_ones, v_mix, v_max, v_zero;
  vec_t        vecs[7];

  initial begin
    v_ramp = pk(0, 1, 2, 3, 4, 5, 6, 7);
    v_ones = pk(1, 1, 1, 1, 1, 1, 1, 1);
    v_mix  = pk(3, 1, 2, 3, 4, 5, 6, 7);
    v_max  = pk(127, 127, 127, 127, 127, 127, 127, 127);
    v_zero = '0;

    vecs[0] = '{v_ramp, 1'b0, 1'b0, 14'd28,   1'b0};
    vecs[1] = '{v_ones, 1'b0, 1'b0, 14'd8,    1'b0};
    vecs[2] = '{v_mix,  1'b0, 1'b0, 14'd31,   1'b0};
    vecs[3] = '{v_max,  1'b0, 1'b0, 14'd1016, 1'b0};
    vecs[4] = '{v_zero, 1'b0, 1'b0, 14'd0,    1'b0};
    vecs[5] = '{v_ramp, 1'b1, 1'b1, 14'd28,   1'b0};
    vecs[6] = '{v_max,  1'b1, 1'b1, 14'd1016, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_mode  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum),   0);
    chk("rst_out_ovf",   int'(out_ovf),   0);
    chk("rst_in_ready",  int'(in_ready),  1);
    release_reset();
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Single beats: latency, value and overflow flag.
    for (int i = 0; i < 7; i++) begin
      add_beat(vecs[i].data, vecs[i].mode, vecs[i].last);
      run_stream(8);
      chk($sformatf("vec%0d_count", i), res_sum.size(), 1);
      if (res_sum.size() >= 1) begin
        chk($sformatf("vec%0d_latency", i), res_cyc[0], 4);
        chk($sformatf("vec%0d_sum", i),     res_sum[0], int'(vecs[i].exp_sum));
        chk($sformatf("vec%0d_ovf", i),     res_ovf[0], int'(vecs[i].exp_ovf));
      end
    end

    // Back-to-back per-beat results on consecutive cycles.
    add_beat(v_ramp, 1'b0, 1'b0);
    add_beat(v_ones, 1'b0, 1'b0);
    add_beat(v_mix,  1'b0, 1'b0);
    run_stream(8);
    chk("b2b_count", res_sum.size(), 3);
    if (res_sum.size() == 3) begin
      chk("b2b_sum0", res_sum[0], 28);
      chk("b2b_sum1", res_sum[1], 8);
      chk("b2b_sum2", res_sum[2], 31);
      chk("b2b_cyc0", res_cyc[0], 4);
      chk("b2b_cyc1", res_cyc[1], 5);
      chk("b2b_cyc2", res_cyc[2], 6);
    end

    // Backpressure: first result held, input blocked, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = v_ramp;
    tick();
    in_data   = v_ones;
    tick();
    in_data   = v_mix;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_hold_valid",   int'(out_valid), 1);
    chk("bp_hold_sum",     int'(out_sum),   28);
    chk("bp_in_ready_low", int'(in_ready),  0);
    tick();
    chk("bp_hold_sum_2",   int'(out_sum),   28);
    res_sum.delete();
    res_ovf.delete();
    res_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample(i);
      tick();
    end
    chk("bp_count", res_sum.size(), 3);
    if (res_sum.size() == 3) begin
      chk("bp_sum0", res_sum[0], 28);
      chk("bp_sum1", res_sum[1], 8);
      chk("bp_sum2", res_sum[2], 31);
    end

    // Three-beat frame, then a fresh two-beat frame must start from zero.
    add_beat(v_ramp, 1'b1, 1'b0);
    add_beat(v_ones, 1'b1, 1'b0);
    add_beat(v_mix,  1'b1, 1'b1);
    run_stream(8);
    chk("frame3_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("frame3_sum", res_sum[0], 67);
      chk("frame3_ovf", res_ovf[0], 0);
      chk("frame3_cyc", res_cyc[0], 6);
    end
    add_beat(v_ones, 1'b1, 1'b0);
    add_beat(v_ones, 1'b1, 1'b1);
    run_stream(8);
    chk("frame_next_count", res_sum.size(), 1);
    if (res_sum.size() == 1) chk("frame_next_sum", res_sum[0], 16);

    // 16 max beats fit in 14 bits; 17 wrap.
    for (int i = 0; i < 16; i++) add_beat(v_max, 1'b1, i == 15);
    run_stream(8);
    chk("frame16_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("frame16_sum", res_sum[0], 16 * 1016);
      chk("frame16_ovf", res_ovf[0], 0);
    end
    for (int i = 0; i < 17; i++) add_beat(v_max, 1'b1, i == 16);
    run_stream(8);
    chk("frame17_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("frame17_sum", res_sum[0], (17 * 1016) % 16384);
      chk("frame17_ovf", res_ovf[0], 1);
    end
    add_beat(v_max, 1'b1, 1'b0);
    add_beat(v_max, 1'b1, 1'b1);
    run_stream(8);
    chk("after_ovf_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("after_ovf_sum", res_sum[0], 2032);
      chk("after_ovf_ovf", res_ovf[0], 0);
    end

    // Reset after the second beat of an open frame.
    in_valid = 1'b1;
    acc_mode = 1'b1;
    in_last  = 1'b0;
    in_data  = v_max;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    do_reset();
    chk("rst_frame_valid",    int'(out_valid), 0);
    chk("rst_frame_sum",      int'(out_sum),   0);
    chk("rst_frame_in_ready", int'(in_ready),  1);
    release_reset();
    add_beat(v_ramp, 1'b1, 1'b1);
    run_stream(10);
    chk("rst_frame_after_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("rst_frame_after_sum", res_sum[0], 28);
      chk("rst_frame_after_cyc", res_cyc[0], 4);
      chk("rst_frame_after_ovf", res_ovf[0], 0);
    end

    // Reset during an active stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_mode  = 1'b0;
    in_data   = v_max;
    tick();
    in_data   = v_mix;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_before_rst_valid", int'(out_valid), 1);
    chk("stall_before_rst_sum",   int'(out_sum),   1016);
    do_reset();
    chk("rst_stall_valid",    int'(out_valid), 0);
    chk("rst_stall_sum",      int'(out_sum),   0);
    chk("rst_stall_in_ready", int'(in_ready),  1);
    release_reset();
    add_beat(v_ramp, 1'b0, 1'b0);
    run_stream(10);
    chk("rst_stall_after_count", res_sum.size(), 1);
    if (res_sum.size() == 1) begin
      chk("rst_stall_after_sum", res_sum[0], 28);
      chk("rst_stall_after_cyc", res_cyc[0], 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
